// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit (master) and imem (slave).
interface instruction_fetch_unit_if #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned INSTR_W = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [ADDR_W-1:0]  addr;
  logic               rsp_valid;
  logic [INSTR_W-1:0] rsp_data;

  modport master (output req_valid, output addr, input req_ready, input rsp_valid, input rsp_data);
  modport slave  (input req_valid, input addr, output req_ready, output rsp_valid, output rsp_data);
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding imem request, IF/ID register load and PC hold control.
// Optional misaligned-fetch trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module instruction_fetch_unit #(
  parameter int unsigned        ADDR_W    = 64,
  parameter int unsigned        INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      pc_in,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   fetch_stall,
  instruction_fetch_unit_if.master imem,
  output logic                   if_id_valid,
  output logic [ADDR_W-1:0]      if_id_pc,
  output logic [INSTR_W-1:0]     if_id_instr,
  output logic                   if_id_fault
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q;
  logic [ADDR_W-1:0]    hold_pc;
  logic [INSTR_W-1:0]   hold_instr;

  logic                 req_valid_c;
  logic                 fetch_stall_c;
  logic                 load_c;
  logic                 hold_we_c;
  logic [ADDR_W-1:0]    load_pc_c;
  logic [INSTR_W-1:0]   load_instr_c;
  logic                 misaligned_c;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic                 load_fault_c;
  assign misaligned_c = (pc_in[1:0] != 2'b00);
`else
  assign misaligned_c = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_REQ;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ:   if (req_valid_c && imem.req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem.rsp_valid) state_d = (stall && !flush) ? S_HOLD : S_REQ;
        else if (flush)     state_d = S_DRAIN;
      end
      S_HOLD:  if (flush || !stall) state_d = S_REQ;
      S_DRAIN: if (imem.rsp_valid) state_d = S_REQ;
    endcase
  end

  // Output / datapath-control logic; reset cycle forces no request and PC hold
  always_comb begin
    req_valid_c   = 1'b0;
    fetch_stall_c = 1'b1;
    load_c        = 1'b0;
    hold_we_c     = 1'b0;
    load_pc_c     = pc_q;
    load_instr_c  = imem.rsp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    load_fault_c  = 1'b0;
`endif
    if (!reset) begin
      unique case (state_q)
        S_REQ: begin
          req_valid_c = !flush && !misaligned_c;
          if (misaligned_c && !flush && !stall) begin
            load_c       = 1'b1;
            load_pc_c    = pc_in;
            load_instr_c = NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
            load_fault_c = 1'b1;
`endif
          end
        end
        S_WAIT: begin
          if (imem.rsp_valid && !flush) begin
            if (stall) hold_we_c = 1'b1;
            else       load_c    = 1'b1;
          end
        end
        S_HOLD: begin
          if (!flush && !stall) begin
            load_c       = 1'b1;
            load_pc_c    = hold_pc;
            load_instr_c = hold_instr;
          end
        end
        S_DRAIN: ;
      endcase
      fetch_stall_c = !(flush || load_c);
    end
  end

  assign imem.req_valid = req_valid_c;
  assign imem.addr      = pc_in;
  assign fetch_stall    = fetch_stall_c;

  // Request PC capture, hold buffer and IF/ID register (flush > stall > load > bubble)
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= '0;
      hold_pc     <= '0;
      hold_instr  <= NOP_INSTR;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else begin
      if (req_valid_c && imem.req_ready) pc_q <= pc_in;
      if (hold_we_c) begin
        hold_pc    <= pc_q;
        hold_instr <= imem.rsp_data;
      end
      if (flush) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end else if (load_c) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= load_pc_c;
        if_id_instr <= load_instr_c;
      end else if (!stall) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset)                    if_id_fault <= 1'b0;
    else if (flush)               if_id_fault <= 1'b0;
    else if (load_c)              if_id_fault <= load_fault_c;
    else if (!stall)              if_id_fault <= 1'b0;
  end
`else
  assign if_id_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized traffic against a transaction-level model.
module tb_instruction_fetch_unit;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [31:0] NOP     = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [63:0] pc_in;
  logic        fetch_stall, if_id_valid, if_id_fault;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;

  instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) imem ();

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .stall(stall), .flush(flush),
    .fetch_stall(fetch_stall), .imem(imem),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .if_id_fault(if_id_fault)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: outstanding request, whether it is to be discarded, and a parked word
  bit          m_busy, m_drop, m_held;
  logic [63:0] m_pc, h_pc;
  logic [31:0] h_instr;
  bit          e_v, e_fault;
  logic [63:0] e_pc;
  logic [31:0] e_instr;

  // Memory: single pending response with countdown
  bit          mem_pend;
  int          mem_cnt;
  int          mem_lat;
  bit          mem_fixed;
  logic [31:0] mem_data, mem_word;

  logic [63:0] pc, flush_target;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit r, input bit s, input bit f, input bit rdy);
    bit rsp, mis, idle, e_req, load, l_fault, e_fs;
    logic [63:0] l_pc;
    logic [31:0] l_instr;
    @(negedge clk);
    chk("if_id_valid", 64'(if_id_valid), 64'(e_v));
    chk("if_id_instr", 64'(if_id_instr), 64'(e_instr));
    chk("if_id_fault", 64'(if_id_fault), 64'(e_fault));
    if (e_v) chk("if_id_pc", if_id_pc, e_pc);

    rsp = mem_pend && (mem_cnt == 0);
    reset = r; stall = s; flush = f; pc_in = pc;
    imem.req_ready = rdy;
    imem.rsp_valid = rsp;
    imem.rsp_data  = rsp ? mem_word : $urandom;
    #1;

    mis   = MIS_EN && (pc[1:0] != 2'b00);
    idle  = !m_busy && !m_held;
    e_req = !r && idle && !f && !mis;
    load = 1'b0; l_pc = '0; l_instr = NOP; l_fault = 1'b0;
    if (!r && !f && !s) begin
      if (m_busy && !m_drop && rsp) begin
        load = 1'b1; l_pc = m_pc; l_instr = mem_word;
      end else if (m_held) begin
        load = 1'b1; l_pc = h_pc; l_instr = h_instr;
      end else if (idle && mis) begin
        load = 1'b1; l_pc = pc; l_instr = NOP; l_fault = 1'b1;
      end
    end
    e_fs = r ? 1'b1 : !(f || load);
    chk("fetch_stall", 64'(fetch_stall), 64'(e_fs));
    chk("imem_req_valid", 64'(imem.req_valid), 64'(e_req));
    if (e_req) chk("imem_addr", imem.addr, pc);

    if (r) begin
      e_v = 0; e_pc = '0; e_instr = NOP; e_fault = 0;
    end else if (f) begin
      e_v = 0; e_instr = NOP; e_fault = 0;
    end else if (load) begin
      e_v = 1; e_pc = l_pc; e_instr = l_instr; e_fault = l_fault;
    end else if (!s) begin
      e_v = 0; e_instr = NOP; e_fault = 0;
    end

    if (r) begin
      m_busy = 0; m_held = 0; m_drop = 0;
    end else if (m_busy) begin
      if (rsp) begin
        if (!m_drop && !f && s) begin
          m_held = 1; h_pc = m_pc; h_instr = mem_word;
        end
        m_busy = 0; m_drop = 0;
      end else if (f) m_drop = 1;
    end else if (m_held) begin
      if (f || !s) m_held = 0;
    end else if (e_req && rdy) begin
      m_busy = 1; m_drop = 0; m_pc = pc;
    end

    if (r) mem_pend = 0;
    else begin
      if (rsp) mem_pend = 0;
      else if (mem_pend) mem_cnt--;
      if (e_req && rdy) begin
        mem_pend = 1;
        mem_cnt  = ((mem_lat != 0) ? mem_lat : int'($urandom_range(1, 4))) - 1;
        mem_word = mem_fixed ? mem_data : $urandom;
      end
    end

    if (!r) begin
      if (f) pc = flush_target;
      else if (!e_fs) pc = pc + 64'd4;
    end
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0; pc_in = '0;
    imem.req_ready = 0; imem.rsp_valid = 0; imem.rsp_data = '0;
    m_busy = 0; m_drop = 0; m_held = 0; m_pc = '0; h_pc = '0; h_instr = NOP;
    e_v = 0; e_pc = '0; e_instr = NOP; e_fault = 0;
    mem_pend = 0; mem_cnt = 0; mem_lat = 1; mem_fixed = 1; mem_data = '0; mem_word = '0;
    pc = '0; flush_target = 64'h100;

    // Reset for two cycles
    cycle(1, 0, 0, 1);
    chk("rst_req_valid", 64'(imem.req_valid), 64'd0);
    chk("rst_fetch_stall", 64'(fetch_stall), 64'd1);
    cycle(1, 0, 0, 1);

    // Best-case fetch at PC 0
    mem_data = 32'h0050_0093;
    cycle(0, 0, 0, 1);
    chk("post_rst_valid", 64'(if_id_valid), 64'd0);
    chk("post_rst_instr", 64'(if_id_instr), 64'h13);
    chk("req_addr0", imem.addr, 64'h0);
    chk("req_stall_n", 64'(fetch_stall), 64'd1);
    cycle(0, 0, 0, 1);
    chk("deliver_fs_low", 64'(fetch_stall), 64'd0);
    mem_data = 32'hA000_0113;
    cycle(0, 0, 0, 1);
    chk("ifid_valid_n2", 64'(if_id_valid), 64'd1);
    chk("ifid_pc_n2", if_id_pc, 64'h0);
    chk("ifid_instr_n2", 64'(if_id_instr), 64'h0050_0093);
    chk("fs_one_cycle", 64'(fetch_stall), 64'd1);
    chk("req_addr4", imem.addr, 64'h4);

    // Response under a 3-cycle stall parks in the hold buffer
    cycle(0, 1, 0, 1);
    chk("hold_fs", 64'(fetch_stall), 64'd1);
    cycle(0, 1, 0, 1);
    chk("hold_ifid_valid", 64'(if_id_valid), 64'd0);
    chk("hold_no_req", 64'(imem.req_valid), 64'd0);
    cycle(0, 1, 0, 1);
    cycle(0, 0, 0, 1);
    chk("unhold_fs", 64'(fetch_stall), 64'd0);

    // Flush while waiting; late 0xDEADBEEF must be drained
    mem_lat = 5; mem_data = 32'hDEAD_BEEF; flush_target = 64'h100;
    cycle(0, 0, 0, 1);
    chk("held_valid", 64'(if_id_valid), 64'd1);
    chk("held_pc", if_id_pc, 64'h4);
    chk("held_instr", 64'(if_id_instr), 64'hA000_0113);
    cycle(0, 0, 1, 1);
    chk("flush_fs", 64'(fetch_stall), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 1);
      chk("drain_no_req", 64'(imem.req_valid), 64'd0);
      chk("drain_valid", 64'(if_id_valid), 64'd0);
    end
    mem_lat = 1; mem_data = 32'h1234_5678; flush_target = 64'h200;
    cycle(0, 0, 0, 1);
    chk("redirect_req", 64'(imem.req_valid), 64'd1);
    chk("redirect_addr", imem.addr, 64'h100);
    chk("no_deadbeef", 64'(if_id_instr), 64'h13);

    // Stall and flush together with the response: dropped
    cycle(0, 1, 1, 1);
    chk("sf_fs", 64'(fetch_stall), 64'd0);
    cycle(0, 0, 0, 1);
    chk("sf_valid", 64'(if_id_valid), 64'd0);
    chk("sf_instr", 64'(if_id_instr), 64'h13);
    chk("sf_addr", imem.addr, 64'h200);
    cycle(0, 0, 0, 0);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned PC traps without touching memory
    pc = 64'h102;
    cycle(0, 0, 0, 1);
    chk("mis_no_req", 64'(imem.req_valid), 64'd0);
    chk("mis_fs", 64'(fetch_stall), 64'd0);
    cycle(0, 0, 0, 0);
    chk("mis_valid", 64'(if_id_valid), 64'd1);
    chk("mis_pc", if_id_pc, 64'h102);
    chk("mis_instr", 64'(if_id_instr), 64'h13);
    chk("mis_fault", 64'(if_id_fault), 64'd1);
    pc = 64'h300;
`endif

    // Randomized traffic, with one mid-run reset
    mem_lat = 0; mem_fixed = 0;
    for (int i = 0; i < 4000; i++) begin
      flush_target = {32'h0, $urandom} & ~64'h3;
      if (MIS_EN && ($urandom_range(0, 3) == 0)) flush_target[1:0] = 2'($urandom);
      cycle((i >= 2000) && (i < 2002), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
    end
    cycle(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
